// File: rtl/b2b3_conv_sched_if.sv
// ---------------------------------------------------------------------------
// b2b3_conv_sched_if
//
// Purpose: bundles the requester-side and converter-side signals of the
// base2_to_base3 converter scheduler.
//
// Signals:
//   req        requester -> sched   level request, one bit per requester
//   req_data   requester -> sched   operands, requester k at [k*IN_W +: IN_W]
//   ack        sched -> requester   one-hot, one-cycle result-valid pulse
//   res_data   sched -> requester   base-3 result, held until next ack
//   err        sched -> requester   timeout flag, qualified by ack
//   busy       sched -> requester   high whenever the scheduler is not idle
//   owner      sched -> requester   current / last granted requester index
//   conv_en    sched -> converter   converter enable
//   conv_base2 sched -> converter   registered converter operand
//   conv_done  converter -> sched   conversion complete
//   conv_base3 converter -> sched   conversion result
//
// Modports:
//   slave  - the scheduler's view
//   master - the surrounding environment (requesters plus converter)
// ---------------------------------------------------------------------------
interface b2b3_conv_sched_if #(
   parameter int NREQ  = 4,
   parameter int ID_W  = 2,
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic [NREQ-1:0]      req;
   logic [NREQ*IN_W-1:0] req_data;
   logic [NREQ-1:0]      ack;
   logic [OUT_W-1:0]     res_data;
   logic                 err;
   logic                 busy;
   logic [ID_W-1:0]      owner;
   logic                 conv_en;
   logic [IN_W-1:0]      conv_base2;
   logic                 conv_done;
   logic [OUT_W-1:0]     conv_base3;

   modport slave (
      input  req, req_data, conv_done, conv_base3,
      output ack, res_data, err, busy, owner, conv_en, conv_base2
   );

   modport master (
      output req, req_data, conv_done, conv_base3,
      input  ack, res_data, err, busy, owner, conv_en, conv_base2
   );
endinterface

// File: rtl/b2b3_conv_sched.sv
// ---------------------------------------------------------------------------
// b2b3_conv_sched
//
// Purpose: shares one base2_to_base3 converter among NREQ requesters using
// round-robin arbitration. The scheduler owns the converter's en/done
// handshake and returns each result on a shared bus with a one-hot ack pulse.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   b2b3_conv_sched_if.slave (req, req_data, ack, res_data, err, busy,
//         owner, conv_en, conv_base2, conv_done, conv_base3)
//
// Optional feature (macro CONV_TIMEOUT_EN):
//   When defined, a CONVERT cycle counter aborts a conversion after TIMEOUT
//   cycles without conv_done, returning res_data=0 with err=1. When undefined,
//   err is tied low and CONVERT waits for conv_done indefinitely.
// ---------------------------------------------------------------------------
module b2b3_conv_sched #(
   parameter int NREQ    = 4,
   parameter int ID_W    = 2,
   parameter int IN_W    = 16,
   parameter int OUT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst,
   b2b3_conv_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      RESPOND
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_last;
   logic [ID_W-1:0]   owner_q;
   logic              conv_en_q;
   logic [IN_W-1:0]   conv_base2_q;
   logic [NREQ-1:0]   ack_q;
   logic [OUT_W-1:0]  res_q;
   logic              busy_q;

   logic              grant_valid;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   scan_idx;
   logic [IN_W-1:0]   operand [NREQ];

`ifdef CONV_TIMEOUT_EN
   // At least 8 bits, wider if TIMEOUT needs it.
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0]  to_cnt;
   logic              err_q;
`endif

   // Split the flat operand bus into per-requester operands; requester k owns
   // bits [k*IN_W +: IN_W].
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         operand[k] = bus.req_data[k*IN_W +: IN_W];
      end
   end

   // Round-robin search starting just after the last grant. The loop runs
   // from the farthest candidate to the nearest so the nearest set bit is the
   // one left standing; the modulo keeps this correct for any NREQ.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int i = NREQ; i >= 1; i--) begin
         scan_idx = ID_W'((int'(rr_last) + i) % NREQ);
         if (bus.req[scan_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Scheduler FSM. Every output is a register. RESPOND is always followed by
   // IDLE, so conv_en stays low for at least two cycles between conversions,
   // giving the converter time to re-arm.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_last      <= ID_W'(NREQ - 1);
         owner_q      <= '0;
         conv_en_q    <= 1'b0;
         conv_base2_q <= '0;
         ack_q        <= '0;
         res_q        <= '0;
         busy_q       <= 1'b0;
`ifdef CONV_TIMEOUT_EN
         to_cnt       <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               ack_q <= '0;
               if (grant_valid) begin
                  owner_q      <= grant_idx;
                  rr_last      <= grant_idx;
                  conv_base2_q <= operand[grant_idx];
                  conv_en_q    <= 1'b1;
                  busy_q       <= 1'b1;
`ifdef CONV_TIMEOUT_EN
                  to_cnt       <= '0;
`endif
                  state        <= CONVERT;
               end
            end

            CONVERT: begin
               // conv_done beats a simultaneous timeout.
               if (bus.conv_done) begin
                  res_q     <= bus.conv_base3;
                  conv_en_q <= 1'b0;
                  ack_q     <= NREQ'(1) << owner_q;
`ifdef CONV_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
                  state     <= RESPOND;
               end
`ifdef CONV_TIMEOUT_EN
               else if (to_cnt == CNT_W'(TIMEOUT)) begin
                  res_q     <= '0;
                  conv_en_q <= 1'b0;
                  ack_q     <= NREQ'(1) << owner_q;
                  err_q     <= 1'b1;
                  state     <= RESPOND;
               end else begin
                  to_cnt    <= to_cnt + 1'b1;
               end
`endif
            end

            RESPOND: begin
               ack_q  <= '0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack        = ack_q;
   assign bus.res_data   = res_q;
   assign bus.busy       = busy_q;
   assign bus.owner      = owner_q;
   assign bus.conv_en    = conv_en_q;
   assign bus.conv_base2 = conv_base2_q;
`ifdef CONV_TIMEOUT_EN
   assign bus.err        = err_q;
`else
   assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_b2b3_conv_sched.sv
// ---------------------------------------------------------------------------
// tb_b2b3_conv_sched
//
// Self-checking bench for b2b3_conv_sched. A behavioural converter with a
// programmable latency answers conv_en; expected results are hand-computed
// base-3 encodings (2 bits per digit, least-significant digit first).
// Honours CONV_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_b2b3_conv_sched;

   localparam int NREQ  = 4;
   localparam int ID_W  = 2;
   localparam int IN_W  = 16;
   localparam int OUT_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   int model_lat  = 3;
   int en_cnt     = 0;
   logic force_done = 1'b0;
   logic model_done;

   b2b3_conv_sched_if #(.NREQ(NREQ), .ID_W(ID_W), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   b2b3_conv_sched #(
      .NREQ(NREQ), .ID_W(ID_W), .IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference base-3 encoder used only by the converter model.
   function automatic logic [31:0] base3(input logic [15:0] v);
      int x;
      logic [31:0] r;
      x = int'(v);
      r = '0;
      for (int d = 0; d < 16; d++) begin
         r[2*d +: 2] = 2'(x % 3);
         x = x / 3;
      end
      return r;
   endfunction

   // Converter model: raises conv_done in the model_lat-th cycle of conv_en
   // (model_lat=0 means it never answers). force_done injects stray pulses.
   always @(negedge clk) begin
      if (bus.conv_en && model_lat > 0) en_cnt = en_cnt + 1;
      else en_cnt = 0;
      model_done = (model_lat > 0) && (en_cnt == model_lat);
      bus.conv_done  = model_done || force_done;
      bus.conv_base3 = model_done ? base3(bus.conv_base2) : 32'hDEAD_BEEF;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*IN_W-1:0] d);
      bus.req      = r;
      bus.req_data = d;
   endtask

   task automatic doReset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   // Steps until ack is nonzero or the budget runs out; expiry is a failure.
   task automatic waitAck(input string name);
      int n;
      n = 0;
      while (bus.ack == '0 && n < 40) begin
         step();
         n++;
      end
      checkOutput({name, "_ack_seen"}, 32'(bus.ack != '0), 32'd1);
   endtask

   typedef struct {
      int          k;
      logic [15:0] data;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [NREQ*IN_W-1:0] d;
      logic [31:0]          held;
      logic [31:0]          exp_sim [4];
      int                   en_cycles;
      int                   exp_order [6];

      vecs[0] = '{k: 0, data: 16'd5,  exp_res: 32'h0000_0006};
      vecs[1] = '{k: 1, data: 16'd3,  exp_res: 32'h0000_0004};
      vecs[2] = '{k: 2, data: 16'd8,  exp_res: 32'h0000_000A};
      vecs[3] = '{k: 3, data: 16'd26, exp_res: 32'h0000_002A};
      vecs[4] = '{k: 0, data: 16'd13, exp_res: 32'h0000_0015};
      vecs[5] = '{k: 1, data: 16'd0,  exp_res: 32'h0000_0000};

      applyStimulus('0, '0);
      step();
      step();
      checkOutput("rst_conv_en", 32'(bus.conv_en), 32'd0);
      checkOutput("rst_ack", 32'(bus.ack), 32'd0);
      checkOutput("rst_res", bus.res_data, 32'd0);
      checkOutput("rst_err", 32'(bus.err), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_owner", 32'(bus.owner), 32'd0);
      checkOutput("rst_base2", 32'(bus.conv_base2), 32'd0);
      rst = 1'b0;
      step();

      // Single requests from the table; other slices carry decoy data.
      for (int v = 0; v < 6; v++) begin
         d = {NREQ{16'hAAAA}};
         d[vecs[v].k*IN_W +: IN_W] = vecs[v].data;
         applyStimulus(NREQ'(1) << vecs[v].k, d);
         step();
         checkOutput("single_conv_en", 32'(bus.conv_en), 32'd1);
         checkOutput("single_base2", 32'(bus.conv_base2), 32'(vecs[v].data));
         checkOutput("single_owner", 32'(bus.owner), 32'(vecs[v].k));
         checkOutput("single_busy", 32'(bus.busy), 32'd1);
         en_cycles = 0;
         while (bus.conv_en && en_cycles < 40) begin
            en_cycles++;
            step();
         end
         checkOutput("single_en_cycles", 32'(en_cycles), 32'd3);
         checkOutput("single_ack", 32'(bus.ack), 32'(1) << vecs[v].k);
         checkOutput("single_res", bus.res_data, vecs[v].exp_res);
         checkOutput("single_err", 32'(bus.err), 32'd0);
         applyStimulus('0, d);
         step();
         checkOutput("single_ack_drop", 32'(bus.ack), 32'd0);
         checkOutput("single_idle", 32'(bus.busy), 32'd0);
      end

      // Reset state after real traffic.
      rst = 1'b1;
      step();
      checkOutput("rst2_res", bus.res_data, 32'd0);
      checkOutput("rst2_base2", 32'(bus.conv_base2), 32'd0);
      checkOutput("rst2_owner", 32'(bus.owner), 32'd0);
      rst = 1'b0;
      step();

      // All four request at once right after reset: served 0,1,2,3.
      exp_sim[0] = 32'h0000_0001;
      exp_sim[1] = 32'h0000_0004;
      exp_sim[2] = 32'h0000_000A;
      exp_sim[3] = 32'h0000_0015;
      d = {16'd13, 16'd8, 16'd3, 16'd1};
      applyStimulus(4'b1111, d);
      for (int g = 0; g < 4; g++) begin
         waitAck("sim");
         checkOutput("sim_ack", 32'(bus.ack), 32'(1) << g);
         checkOutput("sim_res", bus.res_data, exp_sim[g]);
         bus.req[g] = 1'b0;
         step();
         checkOutput("sim_gap_busy", 32'(bus.busy), 32'd0);
         if (g < 3) begin
            step();
            checkOutput("sim_regrant_busy", 32'(bus.busy), 32'd1);
            checkOutput("sim_owner", 32'(bus.owner), 32'(g + 1));
         end
      end
      step();

      // Fairness: 1 and 3 held continuously alternate.
      doReset();
      exp_order = '{1, 3, 1, 3, 1, 3};
      applyStimulus(4'b1010, {16'd26, 16'd9, 16'd3, 16'd5});
      for (int g = 0; g < 6; g++) begin
         waitAck("fair");
         checkOutput("fair_ack", 32'(bus.ack), 32'(1) << exp_order[g]);
         step();
      end
      applyStimulus('0, '0);
      step();
      step();

      // Reset during CONVERT: conv_en drops at once, no ack, re-served later.
      doReset();
      model_lat = 0;
      d = '0;
      d[2*IN_W +: IN_W] = 16'd8;
      applyStimulus(4'b0100, d);
      step();
      checkOutput("abort_conv_en_up", 32'(bus.conv_en), 32'd1);
      step();
      step();
      rst = 1'b1;
      #1;
      checkOutput("abort_conv_en_async", 32'(bus.conv_en), 32'd0);
      checkOutput("abort_ack", 32'(bus.ack), 32'd0);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      step();
      checkOutput("abort_ack_hold", 32'(bus.ack), 32'd0);
      d[2*IN_W +: IN_W] = 16'd9;
      applyStimulus(4'b0100, d);
      model_lat = 3;
      rst = 1'b0;
      step();
      checkOutput("abort_regrant_en", 32'(bus.conv_en), 32'd1);
      checkOutput("abort_reload_base2", 32'(bus.conv_base2), 32'd9);
      checkOutput("abort_owner", 32'(bus.owner), 32'd2);
      waitAck("abort");
      checkOutput("abort_final_ack", 32'(bus.ack), 32'b0100);
      checkOutput("abort_final_res", bus.res_data, 32'h0000_0010);
      checkOutput("abort_final_err", 32'(bus.err), 32'd0);

      // Stray conv_done during RESPOND, then during IDLE.
      applyStimulus('0, d);
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      checkOutput("spur_resp_ack", 32'(bus.ack), 32'd0);
      checkOutput("spur_resp_busy", 32'(bus.busy), 32'd0);
      held = bus.res_data;
      checkOutput("spur_resp_res", held, 32'h0000_0010);
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      step();
      checkOutput("spur_idle_ack", 32'(bus.ack), 32'd0);
      checkOutput("spur_idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("spur_idle_res", bus.res_data, 32'h0000_0010);

      // Converter that never answers.
      doReset();
      model_lat = 0;
      applyStimulus(4'b0001, {48'd0, 16'd5});
      step();
      checkOutput("to_conv_en", 32'(bus.conv_en), 32'd1);
`ifdef CONV_TIMEOUT_EN
      en_cycles = 0;
      while (bus.conv_en && en_cycles < 40) begin
         en_cycles++;
         step();
      end
      checkOutput("to_en_cycles", 32'(en_cycles), 32'd9);
      checkOutput("to_ack", 32'(bus.ack), 32'b0001);
      checkOutput("to_err", 32'(bus.err), 32'd1);
      checkOutput("to_res", bus.res_data, 32'd0);
      applyStimulus('0, '0);
      step();
      checkOutput("to_ack_drop", 32'(bus.ack), 32'd0);
`else
      begin
         int acks_seen;
         int busy_low;
         acks_seen = 0;
         busy_low  = 0;
         for (int c = 0; c < 30; c++) begin
            step();
            if (bus.ack != '0) acks_seen++;
            if (!bus.busy) busy_low++;
         end
         checkOutput("noto_acks", 32'(acks_seen), 32'd0);
         checkOutput("noto_busy_low", 32'(busy_low), 32'd0);
         checkOutput("noto_conv_en", 32'(bus.conv_en), 32'd1);
      end
      applyStimulus('0, '0);
      doReset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

endmodule

// File: doc/b2b3_conv_sched.md
Name: b2b3_conv_sched

Overview:
- Scheduler that shares the single base2_to_base3 converter among NREQ requesters, for example encode lanes and a future decode path.
- Round-robin arbitration; owns the converter's en/done handshake.
- Returns each 28/32-bit base-3 result on a shared result bus with a one-hot ack pulse.
- Sits between the process-level FSMs and the converter instance.

Parameters:
- NREQ, 4: number of requesters.
- ID_W, 2: owner index width, ceil(log2(NREQ)).
- IN_W, 16: base-2 operand width, matching the converter base2_no.
- OUT_W, 32: base-3 result width, matching the converter base3_no (2 bits per digit).
- TIMEOUT, 255: CONVERT cycle limit, used only with CONV_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  level request, one bit per requester.
- req_data  in  NREQ*IN_W  operands; requester k uses bits [k*IN_W +: IN_W].
- ack  out  NREQ  one-hot, one-cycle result-valid pulse.
- res_data  out  OUT_W  result, valid while ack is nonzero, held until the next RESPOND.
- err  out  1  timeout flag, qualified by ack.
- busy  out  1  high in every state except IDLE.
- owner  out  ID_W  index of the current or last granted requester.
- conv_en  out  1  converter enable.
- conv_base2  out  IN_W  converter operand, registered.
- conv_done  in  1  converter done.
- conv_base3  in  OUT_W  converter result.

Behaviour:
- Reset: every output is registered.
  - rst=1 immediately forces state=IDLE.
  - conv_en=0, conv_base2=0, ack=0, res_data=0, err=0, busy=0, owner=0.
  - rr_last=NREQ-1, so requester 0 has highest priority after reset.
  - Reset mid-operation drops conv_en in the same cycle. No ack is issued for an aborted request. A requester still holding req is re-served after release.
- FSM states: IDLE, CONVERT, RESPOND.
- IDLE:
  - If req is nonzero, grant the first set bit searching rr_last+1, rr_last+2, ..., wrapping modulo NREQ.
  - Register owner=grant, rr_last=grant, conv_base2=req_data slice, conv_en=1, then go to CONVERT.
  - If req is zero, stay in IDLE.
- CONVERT:
  - conv_en and conv_base2 are held stable.
  - On conv_done=1: res_data<=conv_base3, conv_en<=0, ack<=onehot(owner), err<=0, then go to RESPOND.
- RESPOND:
  - One cycle; ack is visible and conv_en=0.
  - Next cycle: ack<=0, then go to IDLE.
  - conv_en is therefore low for at least 2 cycles (RESPOND plus IDLE), which lets the converter re-arm.
- conv_done outside CONVERT is ignored. conv_base3 is sampled only in the conv_done cycle.
- Latency: if req rises in IDLE at cycle t, conv_en is high from t+1. If conv_done occurs at cycle d, ack is high at d+1. Minimum request-to-request spacing is conversion time + 3 cycles.
- Requester rules:
  - Hold req and data stable until ack is seen.
  - Drop req at the edge that ends the ack cycle.
  - req still high in the following IDLE counts as a new request, at lowest priority, because rr_last equals that requester.
- Changes to req or req_data of non-owners during CONVERT have no effect. A non-owner's req deasserting before it is granted is a legal withdrawal.
- Arithmetic: the round-robin index wraps modulo NREQ, and NREQ is not required to be a power of 2. Slice offsets are computed as owner*IN_W.

Optional Feature:
- Macro: CONV_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to CONVERT and increments each CONVERT cycle without conv_done.
  - When the counter reaches TIMEOUT, the block drops conv_en, sets res_data=0, err=1, ack=onehot(owner), and goes to RESPOND.
  - conv_done in the same cycle as the timeout wins, giving a normal result with err=0.
- When undefined:
  - No counter is built and err is tied to 0.
  - CONVERT waits for conv_done indefinitely.

Test Plan:
- Single request: converter model with 3-cycle latency; req[0]=1, req_data[15:0]=16'h0005 -> conv_base2=16'h0005, conv_en high 3 cycles, ack=4'b0001 for exactly 1 cycle, res_data=32'h0000_0006 (digits 1,2), err=0.
- Simultaneous requests: req=4'b1111 right after reset with distinct data -> acks in order 0,1,2,3, each with its own result, busy low for exactly 1 cycle between grants.
- Fairness: req[1] and req[3] held high continuously -> grant order 1,3,1,3,...; no requester is granted twice in a row while the other is waiting.
- Reset mid-operation: rst pulsed during CONVERT -> conv_en=0 in the same cycle, no ack; after release with req=4'b0100 still high -> requester 2 is granted, conv_base2 is reloaded, and the conversion completes normally.
- Spurious done: conv_done pulsed while in IDLE and while in RESPOND -> no state change, no extra ack, res_data unchanged.
- Timeout: CONV_TIMEOUT_EN defined, TIMEOUT=8, conv_done never asserted -> ack=onehot(owner), err=1, res_data=0, 9 cycles after conv_en rises. Same stimulus with the macro undefined -> busy stays high and no ack is issued.
